// File: rtl/adder4.sv
// adder4: WIDTH-bit ripple-carry adder with a registered result copy.
// Define ADD4_CARRY_IN_EN to add the Cin port (c[0] = Cin).
module adder4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef ADD4_CARRY_IN_EN
  input  logic             Cin,
`endif
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic [WIDTH-1:0] S_q,
  output logic             C_q
);

  logic             cin_w;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_d;
  logic             c_d;

`ifdef ADD4_CARRY_IN_EN
  assign cin_w = Cin;
`else
  assign cin_w = 1'b0;
`endif

  // ripple chain of full adders, LSB first
  always_comb begin
    c    = '0;
    s_d  = '0;
    c[0] = cin_w;
    for (int i = 0; i < WIDTH; i++) begin
      s_d[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign c_d = c[WIDTH];
  assign S   = s_d;
  assign C   = c_d;
  assign V   = c[WIDTH] ^ c[WIDTH-1];

  // one-cycle registered copy for pipelined consumers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_q <= '0;
      C_q <= 1'b0;
    end else begin
      S_q <= s_d;
      C_q <= c_d;
    end
  end

endmodule

// File: tb/tb_adder4.sv
// tb_adder4: randomized and directed checks of adder4 against an
// arithmetic reference model.
module tb_adder4;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       c;
  logic       v;
  logic [3:0] s_q;
  logic       c_q;

  int n_pass;
  int n_total;

  adder4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a),
    .B     (b),
`ifdef ADD4_CARRY_IN_EN
    .Cin   (cin),
`endif
    .S     (s),
    .C     (c),
    .V     (v),
    .S_q   (s_q),
    .C_q   (c_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // plain unsigned sum, 5 bits wide
  function automatic logic [4:0] ref_sum(input int x, input int y,
                                         input int ci);
    int t;
    t = x + y + ci;
    return t[4:0];
  endfunction

  // signed overflow: true sum leaves the 4-bit two's-complement range
  function automatic logic ref_ovf(input int x, input int y,
                                   input int ci);
    int sx;
    int sy;
    int t;
    sx = (x >= 8) ? x - 16 : x;
    sy = (y >= 8) ? y - 16 : y;
    t  = sx + sy + ci;
    return (t > 7) || (t < -8);
  endfunction

  task automatic test_reset();
    logic [4:0] e;
    rst_n = 1'b0;
    a = 4'd5;
    b = 4'd3;
    cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = ref_sum(5, 3, 0);
    n_total++;
    if ({c_q, s_q} !== 5'd0)
      $display("FAIL reset_regs got %0d expected 0", {c_q, s_q});
    else n_pass++;
    n_total++;
    if ({c, s} !== e)
      $display("FAIL reset_comb got %0d expected %0d", {c, s}, e);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    int         pa[256];
    logic [4:0] e;
    logic [4:0] prev;
    logic       ev;
    int         j;
    int         tmp;
    bit         have_prev;
    int         bad;
    for (int i = 0; i < 256; i++) pa[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = pa[i];
      pa[i] = pa[j];
      pa[j] = tmp;
    end
    have_prev = 1'b0;
    bad = 0;
    prev = '0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      a = 4'(pa[i] / 16);
      b = 4'(pa[i] % 16);
      cin = 1'b0;
      @(negedge clk);
      if (have_prev) begin
        n_total++;
        if ({c_q, s_q} !== prev) begin
          if (bad < 10)
            $display("FAIL sweep_reg got %0d expected %0d",
                     {c_q, s_q}, prev);
          bad++;
        end else n_pass++;
      end
      e  = ref_sum(int'(a), int'(b), 0);
      ev = ref_ovf(int'(a), int'(b), 0);
      n_total++;
      if ({v, c, s} !== {ev, e}) begin
        if (bad < 10)
          $display("FAIL sweep a=%0d b=%0d got v%0d cs%0d expected v%0d cs%0d",
                   a, b, v, {c, s}, ev, e);
        bad++;
      end else n_pass++;
      prev = e;
      have_prev = 1'b1;
    end
  endtask

  task automatic test_boundaries();
    int tab[7][5];
    tab = '{'{15, 1, 0, 1, 0}, '{15, 15, 14, 1, 0}, '{0, 0, 0, 0, 0},
            '{8, 8, 0, 1, 1}, '{7, 1, 8, 0, 1}, '{8, 15, 7, 1, 1},
            '{3, 2, 5, 0, 0}};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      a = 4'(tab[i][0]);
      b = 4'(tab[i][1]);
      cin = 1'b0;
      @(negedge clk);
      n_total++;
      if (s !== 4'(tab[i][2]) || c !== 1'(tab[i][3]) ||
          v !== 1'(tab[i][4]))
        $display("FAIL boundary a=%0d b=%0d got s%0d c%0d v%0d expected s%0d c%0d v%0d",
                 a, b, s, c, v, tab[i][2], tab[i][3], tab[i][4]);
      else n_pass++;
    end
  endtask

  task automatic test_registered();
    @(posedge clk);
    #1;
    a = 4'd9;
    b = 4'd9;
    cin = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if (s_q !== 4'd2 || c_q !== 1'b1)
      $display("FAIL reg_capture got s_q%0d c_q%0d expected s_q2 c_q1",
               s_q, c_q);
    else n_pass++;
    @(negedge clk);
    a = 4'd0;
    #2;
    n_total++;
    if (s_q !== 4'd2 || c_q !== 1'b1 || {c, s} !== 5'd9)
      $display("FAIL reg_hold got s_q%0d c_q%0d cs%0d expected 2 1 9",
               s_q, c_q, {c, s});
    else n_pass++;
    a = 4'd9;
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    n_total++;
    if (s_q !== 4'd2 || c_q !== 1'b1)
      $display("FAIL arst_pre got s_q%0d c_q%0d expected 2 1", s_q, c_q);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (s_q !== 4'd0 || c_q !== 1'b0)
      $display("FAIL arst_clear got s_q%0d c_q%0d expected 0 0", s_q, c_q);
    else n_pass++;
    n_total++;
    if (s !== 4'd2 || c !== 1'b1 || v !== 1'b1)
      $display("FAIL arst_comb got s%0d c%0d v%0d expected 2 1 1", s, c, v);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (s_q !== 4'd0 || c_q !== 1'b0)
      $display("FAIL arst_hold got s_q%0d c_q%0d expected 0 0", s_q, c_q);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (s_q !== 4'd2 || c_q !== 1'b1)
      $display("FAIL arst_release got s_q%0d c_q%0d expected 2 1", s_q, c_q);
    else n_pass++;
  endtask

`ifdef ADD4_CARRY_IN_EN
  task automatic test_carry_in();
    logic [4:0] e;
    logic       ev;
    int tab[3][5];
    tab = '{'{15, 0, 1, 0, 1}, '{6, 9, 1, 0, 1}, '{15, 15, 1, 15, 1}};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      a = 4'(tab[i][0]);
      b = 4'(tab[i][1]);
      cin = 1'(tab[i][2]);
      @(negedge clk);
      n_total++;
      if (s !== 4'(tab[i][3]) || c !== 1'(tab[i][4]))
        $display("FAIL cin_dir a=%0d b=%0d got s%0d c%0d expected s%0d c%0d",
                 a, b, s, c, tab[i][3], tab[i][4]);
      else n_pass++;
    end
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      a = 4'($urandom);
      b = 4'($urandom);
      cin = 1'($urandom);
      @(negedge clk);
      e  = ref_sum(int'(a), int'(b), int'(cin));
      ev = ref_ovf(int'(a), int'(b), int'(cin));
      n_total++;
      if ({v, c, s} !== {ev, e})
        $display("FAIL cin_rand a=%0d b=%0d ci=%0d got %0d expected %0d",
                 a, b, cin, {v, c, s}, {ev, e});
      else n_pass++;
    end
    cin = 1'b0;
  endtask
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    test_reset();
    test_sweep();
    test_boundaries();
    test_registered();
    test_async_reset();
`ifdef ADD4_CARRY_IN_EN
    test_carry_in();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
